// File: rtl/rf_arbiter_if.sv
// Register-file port bundle between the core pipeline, the debug requester and rf_arbiter.
// The master modport is the environment side; the arbiter uses slave.
interface rf_arbiter_if;
    logic [4:0]  id_reg1_raddr_i;
    logic [4:0]  id_reg2_raddr_i;
    logic        ex_reg_we_i;
    logic [4:0]  ex_reg_waddr_i;
    logic [31:0] ex_reg_wdata_i;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic [31:0] reg1_rdata_i;
    logic [4:0]  reg1_raddr_o;
    logic [4:0]  reg2_raddr_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        hold_o;
    logic        dbg_gnt_o;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;

    modport master (
        output id_reg1_raddr_i, id_reg2_raddr_i, ex_reg_we_i, ex_reg_waddr_i, ex_reg_wdata_i,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, reg1_rdata_i,
        input  reg1_raddr_o, reg2_raddr_o, reg_we_o, reg_waddr_o, reg_wdata_o,
        input  hold_o, dbg_gnt_o, dbg_ack_o, dbg_rdata_o
    );

    modport slave (
        input  id_reg1_raddr_i, id_reg2_raddr_i, ex_reg_we_i, ex_reg_waddr_i, ex_reg_wdata_i,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, reg1_rdata_i,
        output reg1_raddr_o, reg2_raddr_o, reg_we_o, reg_waddr_o, reg_wdata_o,
        output hold_o, dbg_gnt_o, dbg_ack_o, dbg_rdata_o
    );
endinterface

// File: rtl/rf_arbiter.sv
// Shares the register file between the core pipeline and a debug requester.
// Define RF_ARB_FAIRNESS_EN to bound grant windows (MAX_GRANT) and enforce core time (CORE_MIN).
module rf_arbiter #(
    parameter int unsigned MAX_GRANT = 8,
    parameter int unsigned CORE_MIN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    rf_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, GRANT, RELEASE} state_t;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        access;
    logic        idle_ok;
    logic        win_done;

    // A core write always owns the write port, so a colliding debug access is simply not taken.
    assign access = !rst && (state_q == GRANT) && bus.dbg_req_i && !bus.ex_reg_we_i;

`ifdef RF_ARB_FAIRNESS_EN
    localparam int unsigned IW = $clog2(CORE_MIN + 2);
    localparam int unsigned AW = $clog2(MAX_GRANT + 2);

    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [AW-1:0] acc_cnt_q, acc_cnt_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        acc_cnt_d  = acc_cnt_q;
        if (state_q == RELEASE) begin
            idle_cnt_d = '0;
        end else if ((state_q == IDLE) && (idle_cnt_q < IW'(CORE_MIN))) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (state_q == DRAIN) begin
            acc_cnt_d = '0;
        end else if (access && (acc_cnt_q < AW'(MAX_GRANT))) begin
            acc_cnt_d = acc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= IW'(CORE_MIN);
            acc_cnt_q  <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
        end
    end

    assign idle_ok  = (idle_cnt_q >= IW'(CORE_MIN));
    assign win_done = access && ((acc_cnt_q + 1'b1) >= AW'(MAX_GRANT));
`else
    assign idle_ok  = 1'b1;
    assign win_done = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        bus.reg1_raddr_o = bus.id_reg1_raddr_i;
        bus.reg2_raddr_o = bus.id_reg2_raddr_i;
        bus.reg_we_o     = bus.ex_reg_we_i;
        bus.reg_waddr_o  = bus.ex_reg_waddr_i;
        bus.reg_wdata_o  = bus.ex_reg_wdata_i;
        bus.hold_o       = 1'b0;
        bus.dbg_gnt_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dbg_req_i && idle_ok) state_d = DRAIN;
            end
            DRAIN: begin
                bus.hold_o = 1'b1;
                state_d    = GRANT;
            end
            GRANT: begin
                bus.hold_o       = 1'b1;
                bus.dbg_gnt_o    = 1'b1;
                bus.reg1_raddr_o = bus.dbg_addr_i;
                bus.reg2_raddr_o = '0;
                if (access) begin
                    bus.reg_we_o    = bus.dbg_we_i && (bus.dbg_addr_i != '0);
                    bus.reg_waddr_o = bus.dbg_addr_i;
                    bus.reg_wdata_o = bus.dbg_wdata_i;
                end
                if (!bus.dbg_req_i || win_done) state_d = RELEASE;
            end
            RELEASE: begin
                bus.hold_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are forced low combinationally so reset takes effect without a clock edge.
        if (rst) begin
            bus.reg1_raddr_o = '0;
            bus.reg2_raddr_o = '0;
            bus.reg_we_o     = 1'b0;
            bus.reg_waddr_o  = '0;
            bus.reg_wdata_o  = '0;
            bus.hold_o       = 1'b0;
            bus.dbg_gnt_o    = 1'b0;
        end
    end

    always_comb begin
        ack_d   = access;
        rdata_d = rdata_q;
        if (access && !bus.dbg_we_i) rdata_d = bus.reg1_rdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.dbg_ack_o   = ack_q;
    assign bus.dbg_rdata_o = rdata_q;
endmodule

// File: tb/tb_rf_arbiter.sv
// Randomized self-checking bench for rf_arbiter against a register-file and requester model.
// Build with RF_ARB_FAIRNESS_EN defined to check bounded grant windows.
module tb_rf_arbiter;
    localparam int unsigned MAX_GRANT = 8;
    localparam int unsigned CORE_MIN  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_arbiter_if bus();

    rf_arbiter #(.MAX_GRANT(MAX_GRANT), .CORE_MIN(CORE_MIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Physical register file written only by the DUT's write port; mdl is what it should hold.
    logic [31:0] phys [32] = '{default: '0};
    logic [31:0] mdl  [32];
    always @(posedge clk) if (bus.reg_we_o) phys[bus.reg_waddr_o] <= bus.reg_wdata_o;
    assign bus.reg1_rdata_i = phys[bus.reg1_raddr_o];

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    logic [31:0] last_rd  = '0;
    int unsigned acc_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_quiet();
        bus.dbg_req_i       = 1'b0;
        bus.dbg_we_i        = 1'b0;
        bus.dbg_addr_i      = '0;
        bus.dbg_wdata_i     = '0;
        bus.ex_reg_we_i     = 1'b0;
        bus.ex_reg_waddr_i  = '0;
        bus.ex_reg_wdata_i  = '0;
        bus.id_reg1_raddr_i = '0;
        bus.id_reg2_raddr_i = '0;
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            drive_quiet();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_raddr1"}, 32'(bus.reg1_raddr_o), 0);
        check({tag, "_raddr2"}, 32'(bus.reg2_raddr_o), 0);
        check({tag, "_we"},     32'(bus.reg_we_o), 0);
        check({tag, "_waddr"},  32'(bus.reg_waddr_o), 0);
        check({tag, "_wdata"},  bus.reg_wdata_o, 0);
        check({tag, "_hold"},   32'(bus.hold_o), 0);
        check({tag, "_gnt"},    32'(bus.dbg_gnt_o), 0);
        check({tag, "_ack"},    32'(bus.dbg_ack_o), 0);
        check({tag, "_rdata"},  bus.dbg_rdata_o, 0);
    endtask

    task automatic core_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_quiet();
        bus.ex_reg_we_i     = 1'b1;
        bus.ex_reg_waddr_i  = a;
        bus.ex_reg_wdata_i  = d;
        bus.id_reg1_raddr_i = 5'($urandom_range(0, 31));
        bus.id_reg2_raddr_i = 5'($urandom_range(0, 31));
        #1;
        check("core_we",     32'(bus.reg_we_o), 1);
        check("core_waddr",  32'(bus.reg_waddr_o), 32'(a));
        check("core_wdata",  bus.reg_wdata_o, d);
        check("core_raddr1", 32'(bus.reg1_raddr_o), 32'(bus.id_reg1_raddr_i));
        check("core_raddr2", 32'(bus.reg2_raddr_o), 32'(bus.id_reg2_raddr_i));
        check("core_hold",   32'(bus.hold_o), 0);
        if (a != 0) mdl[a] = d;
    endtask

    // Single debug access started from IDLE with the core-time requirement already met.
    task automatic dbg_single(input string tag, input logic we, input logic [4:0] addr,
                              input logic [31:0] wdata, input logic collide);
        logic [31:0] cdata;
        logic [31:0] exp_rd;
        @(negedge clk);
        drive_quiet();
        bus.dbg_req_i   = 1'b1;
        bus.dbg_we_i    = we;
        bus.dbg_addr_i  = addr;
        bus.dbg_wdata_i = wdata;
        #1;
        check({tag, "_req_hold"}, 32'(bus.hold_o), 0);
        @(negedge clk); #1;
        check({tag, "_drain_hold"}, 32'(bus.hold_o), 1);
        check({tag, "_drain_gnt"},  32'(bus.dbg_gnt_o), 0);
        @(negedge clk); #1;
        check({tag, "_gnt"}, 32'(bus.dbg_gnt_o), 1);
        if (collide) begin
            cdata = $urandom;
            bus.ex_reg_we_i    = 1'b1;
            bus.ex_reg_waddr_i = 5'd3;
            bus.ex_reg_wdata_i = cdata;
            #1;
            check({tag, "_coll_we"},    32'(bus.reg_we_o), 1);
            check({tag, "_coll_waddr"}, 32'(bus.reg_waddr_o), 3);
            check({tag, "_coll_wdata"}, bus.reg_wdata_o, cdata);
            mdl[3] = cdata;
            @(negedge clk);
            bus.ex_reg_we_i = 1'b0;
            #1;
            check({tag, "_coll_noack"}, 32'(bus.dbg_ack_o), 0);
            check({tag, "_coll_gnt"},   32'(bus.dbg_gnt_o), 1);
        end
        check({tag, "_raddr1"}, 32'(bus.reg1_raddr_o), 32'(addr));
        check({tag, "_raddr2"}, 32'(bus.reg2_raddr_o), 0);
        check({tag, "_we"}, 32'(bus.reg_we_o), 32'(we && (addr != 0)));
        if (we && (addr != 0)) begin
            check({tag, "_waddr"}, 32'(bus.reg_waddr_o), 32'(addr));
            check({tag, "_wdata"}, bus.reg_wdata_o, wdata);
        end
        exp_rd = mdl[addr];
        if (we && (addr != 0)) mdl[addr] = wdata;
        @(negedge clk);
        bus.dbg_req_i = 1'b0;
        #1;
        check({tag, "_ack"}, 32'(bus.dbg_ack_o), 1);
        if (!we) last_rd = exp_rd;
        check({tag, "_rdata"}, bus.dbg_rdata_o, last_rd);
        check({tag, "_ack_we"}, 32'(bus.reg_we_o), 0);
        @(negedge clk); #1;
        check({tag, "_rel_hold"}, 32'(bus.hold_o), 1);
        check({tag, "_rel_gnt"},  32'(bus.dbg_gnt_o), 0);
        check({tag, "_rel_ack"},  32'(bus.dbg_ack_o), 0);
        @(negedge clk); #1;
        check({tag, "_idle_hold"}, 32'(bus.hold_o), 0);
    endtask

    // Requester holding dbg_req_i for ncyc cycles with random accesses, optional core collisions.
    task automatic burst(input string tag, input int unsigned ncyc, input logic coll_en);
        logic        pend, pwe, prev_gnt, req_now, ex_now;
        logic [31:0] pexp, ex_d;
        logic [4:0]  ex_a;
        int unsigned win_acc, idle_run, ends;
        pend = 1'b0; pwe = 1'b0; prev_gnt = 1'b0; pexp = '0;
        win_acc = 0; idle_run = 0; ends = 0;
        for (int unsigned c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            req_now = (c < ncyc);
            ex_now  = coll_en && req_now && ($urandom_range(0, 5) == 0);
            ex_a    = 5'($urandom_range(1, 31));
            ex_d    = $urandom;
            bus.dbg_req_i       = req_now;
            bus.dbg_we_i        = 1'($urandom_range(0, 1));
            bus.dbg_addr_i      = 5'($urandom_range(0, 31));
            bus.dbg_wdata_i     = $urandom;
            bus.ex_reg_we_i     = ex_now;
            bus.ex_reg_waddr_i  = ex_a;
            bus.ex_reg_wdata_i  = ex_d;
            bus.id_reg1_raddr_i = 5'($urandom_range(0, 31));
            bus.id_reg2_raddr_i = 5'($urandom_range(0, 31));
            #1;
            check({tag, "_ack"}, 32'(bus.dbg_ack_o), 32'(pend));
            if (pend && !pwe) last_rd = pexp;
            check({tag, "_rdata"}, bus.dbg_rdata_o, last_rd);
            pend = 1'b0;
            if (bus.dbg_gnt_o) begin
                check({tag, "_gnt_hold"}, 32'(bus.hold_o), 1);
                check({tag, "_raddr1"}, 32'(bus.reg1_raddr_o), 32'(bus.dbg_addr_i));
                check({tag, "_raddr2"}, 32'(bus.reg2_raddr_o), 0);
                if (ex_now) begin
                    check({tag, "_coll_we"},    32'(bus.reg_we_o), 1);
                    check({tag, "_coll_waddr"}, 32'(bus.reg_waddr_o), 32'(ex_a));
                    check({tag, "_coll_wdata"}, bus.reg_wdata_o, ex_d);
                    mdl[ex_a] = ex_d;
                end else if (req_now) begin
                    check({tag, "_we"}, 32'(bus.reg_we_o),
                          32'(bus.dbg_we_i && (bus.dbg_addr_i != 0)));
                    if (bus.dbg_we_i && (bus.dbg_addr_i != 0)) begin
                        check({tag, "_waddr"}, 32'(bus.reg_waddr_o), 32'(bus.dbg_addr_i));
                        check({tag, "_wdata"}, bus.reg_wdata_o, bus.dbg_wdata_i);
                    end
                    pexp = mdl[bus.dbg_addr_i];
                    pwe  = bus.dbg_we_i;
                    pend = 1'b1;
                    win_acc++;
                    acc_total++;
                    if (bus.dbg_we_i && (bus.dbg_addr_i != 0)) mdl[bus.dbg_addr_i] = bus.dbg_wdata_i;
                end else begin
                    check({tag, "_tail_we"}, 32'(bus.reg_we_o), 0);
                end
            end else begin
                check({tag, "_pass_raddr1"}, 32'(bus.reg1_raddr_o), 32'(bus.id_reg1_raddr_i));
                check({tag, "_pass_raddr2"}, 32'(bus.reg2_raddr_o), 32'(bus.id_reg2_raddr_i));
                check({tag, "_pass_we"}, 32'(bus.reg_we_o), 32'(ex_now));
                if (ex_now) begin
                    check({tag, "_pass_waddr"}, 32'(bus.reg_waddr_o), 32'(ex_a));
                    check({tag, "_pass_wdata"}, bus.reg_wdata_o, ex_d);
                    mdl[ex_a] = ex_d;
                end
            end
            if (bus.dbg_gnt_o && !prev_gnt && (ends > 0)) begin
                check({tag, "_core_min"}, 32'(idle_run >= CORE_MIN), 1);
            end
            if (!bus.dbg_gnt_o && prev_gnt && req_now) begin
                ends++;
`ifdef RF_ARB_FAIRNESS_EN
                check({tag, "_win_len"}, win_acc, MAX_GRANT);
`else
                check({tag, "_held"}, 32'(bus.dbg_gnt_o), 1);
`endif
                win_acc  = 0;
                idle_run = 0;
            end
            if (!bus.hold_o) idle_run++;
            prev_gnt = bus.dbg_gnt_o;
        end
`ifdef RF_ARB_FAIRNESS_EN
        if (ncyc >= 20) check({tag, "_windows"}, 32'(ends >= 1), 1);
`else
        check({tag, "_windows"}, ends, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        for (int unsigned i = 0; i < 32; i++) mdl[i] = '0;
        acc_total = 0;
        drive_quiet();
        rst = 1'b1;
        bus.id_reg1_raddr_i = 5'd7;
        bus.id_reg2_raddr_i = 5'd9;
        bus.ex_reg_we_i     = 1'b1;
        bus.ex_reg_waddr_i  = 5'd4;
        bus.ex_reg_wdata_i  = 32'hA5A5_5A5A;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        drive_quiet();
        rst = 1'b0;

        for (int unsigned i = 1; i < 32; i++) core_write(5'(i), $urandom);
        idle_cycles(8);

        dbg_single("wr5", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
        idle_cycles(8);
        dbg_single("rd5a", 1'b0, 5'd5, 32'h0, 1'b0);
        core_write(5'd5, 32'h1234_5678);
        idle_cycles(8);
        dbg_single("rd5", 1'b0, 5'd5, 32'h0, 1'b0);
        check("rd5_value", last_rd, 32'h1234_5678);
        idle_cycles(8);
        dbg_single("coll_wr", 1'b1, 5'($urandom_range(4, 31)), $urandom, 1'b1);
        idle_cycles(8);
        dbg_single("coll_rd", 1'b0, 5'd3, 32'h0, 1'b1);
        idle_cycles(8);
        dbg_single("x0", 1'b1, 5'd0, $urandom, 1'b0);
        idle_cycles(8);

        // Reset asserted while a debug write is being presented in GRANT.
        d = $urandom;
        @(negedge clk);
        drive_quiet();
        bus.dbg_req_i       = 1'b1;
        bus.dbg_we_i        = 1'b1;
        bus.dbg_addr_i      = 5'd9;
        bus.dbg_wdata_i     = d;
        bus.id_reg1_raddr_i = 5'd7;
        bus.id_reg2_raddr_i = 5'd9;
        repeat (2) @(negedge clk);
        #1;
        check("mg_gnt", 32'(bus.dbg_gnt_o), 1);
        rst = 1'b1;
        #1;
        check_all_zero("mg_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mg_idle_hold", 32'(bus.hold_o), 0);
        check("mg_no_write", phys[9], mdl[9]);
        last_rd = '0;
        @(negedge clk); #1;
        check("mg_drain_hold", 32'(bus.hold_o), 1);
        check("mg_drain_gnt", 32'(bus.dbg_gnt_o), 0);
        @(negedge clk); #1;
        check("mg_regnt", 32'(bus.dbg_gnt_o), 1);
        check("mg_we", 32'(bus.reg_we_o), 1);
        check("mg_wdata", bus.reg_wdata_o, d);
        mdl[9] = d;
        @(negedge clk);
        bus.dbg_req_i = 1'b0;
        #1;
        check("mg_ack", 32'(bus.dbg_ack_o), 1);
        check("mg_rdata", bus.dbg_rdata_o, last_rd);
        idle_cycles(8);

        burst("fair20", 20, 1'b0);
        idle_cycles(8);
        burst("rnd60a", 60, 1'b1);
        idle_cycles(8);
        burst("rnd60b", 60, 1'b1);
        idle_cycles(8);
        check("bursts_granted", 32'(acc_total > 0), 1);

        for (int unsigned i = 0; i < 32; i++) check($sformatf("regfile_x%0d", i), phys[i], mdl[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 SHALL have parameter MAX_GRANT, default 8: maximum debug accesses per grant window.
REQ-002 SHALL have parameter CORE_MIN, default 4: minimum IDLE cycles for the core between grant windows.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_reg1_raddr_i / id_reg2_raddr_i  in  5  decode-stage read addresses.
- ex_reg_we_i  in  1  core write enable.
- ex_reg_waddr_i  in  5  core write address.
- ex_reg_wdata_i  in  32  core write data.
- dbg_req_i  in  1  debug requester access request.
- dbg_we_i  in  1  debug write (1) or read (0).
- dbg_addr_i  in  5  debug register address.
- dbg_wdata_i  in  32  debug write data.
- reg1_rdata_i  in  32  register file port-1 read data.
- reg1_raddr_o / reg2_raddr_o  out  5  register file read addresses.
- reg_we_o  out  1  register file write enable.
- reg_waddr_o  out  5  register file write address.
- reg_wdata_o  out  32  register file write data.
- hold_o  out  1  pipeline hold to fetch/decode.
- dbg_gnt_o  out  1  debug owns the register file.
- dbg_ack_o  out  1  one-cycle access-complete pulse.
- dbg_rdata_o  out  32  registered debug read data.

Function
REQ-004 SHALL implement FSM states IDLE, DRAIN, GRANT, RELEASE.
REQ-005 IDLE: core addresses and write pass straight to the regfile ports; hold_o=0; dbg_gnt_o=0.
REQ-006 IDLE->DRAIN when dbg_req_i=1 and the IDLE-cycle counter is at least CORE_MIN.
REQ-007 DRAIN lasts exactly 1 cycle: hold_o=1, core write still passes so the in-flight EX write retires; DRAIN->GRANT.
REQ-008 GRANT, routing: hold_o=1, dbg_gnt_o=1, reg1_raddr_o=dbg_addr_i, reg2_raddr_o=0.
REQ-009 GRANT, access: each cycle with dbg_req_i=1 performs one access.
- Write: drives reg_we_o=1 with dbg_addr_i and dbg_wdata_i.
- Read: samples reg1_rdata_i into dbg_rdata_o.
- Completion: dbg_ack_o pulses the following cycle.
REQ-010 GRANT with ex_reg_we_i=1: the core write takes the write port, and the debug access is neither performed nor acked that cycle (the requester retries).
REQ-011 A debug write to address 0 SHALL be acked with reg_we_o=0.
REQ-012 GRANT->RELEASE when dbg_req_i=0, or when the access counter reaches MAX_GRANT (fairness only, see REQ-019).
REQ-013 RELEASE lasts 1 cycle: hold_o=1, dbg_gnt_o=0, core routing restored; then ->IDLE, clearing the IDLE-cycle counter.
REQ-014 The IDLE-cycle counter and the access counter SHALL saturate and never wrap.
REQ-015 Read latency SHALL be exactly 1 cycle from the accepting GRANT cycle to dbg_ack_o with valid dbg_rdata_o.
REQ-016 dbg_rdata_o SHALL hold its value until the next read ack.

Reset
REQ-017 On rst=1 the FSM SHALL go to IDLE immediately, including mid-GRANT, and all outputs SHALL be 0.
- Counters: the IDLE counter resets to CORE_MIN (first request is not delayed); the access counter resets to 0.
REQ-018 A pending, unacked debug access at reset SHALL be dropped with no write performed.

Configuration
REQ-019 Macro RF_ARB_FAIRNESS_EN:
- Defined: MAX_GRANT forces GRANT->RELEASE, and CORE_MIN gates re-entry into DRAIN.
- Undefined: the grant is unbounded (held while dbg_req_i=1), IDLE->DRAIN needs only dbg_req_i, and neither counter is instantiated.

Verification
REQ-020 Scenarios the bench SHALL cover:
- Debug write: dbg_req_i=1, dbg_we_i=1, addr=5, wdata=0xDEADBEEF.
  -> DRAIN 1 cycle, GRANT, then reg_we_o=1, waddr=5 for 1 cycle, ack next cycle.
- Debug read: read of x5 with reg1_rdata_i=0x12345678.
  -> reg1_raddr_o=5 in GRANT; the next cycle gives dbg_ack_o=1 and dbg_rdata_o=0x12345678.
- Collision: ex_reg_we_i=1 to x3 in the first GRANT cycle.
  -> x3 written by the core, no ack that cycle; the debug access completes one cycle later.
- Fairness (macro defined): dbg_req_i held high for 20 cycles.
  -> RELEASE after 8 acks, 4+ IDLE cycles with hold_o=0, then DRAIN again.
- x0 write: debug write to addr 0.
  -> ack asserted, reg_we_o stays 0.
- Reset mid-grant: rst pulsed during GRANT.
  -> all outputs 0 asynchronously; IDLE on release; a new request is accepted immediately.
